// File: rtl/cfu_ram_pkg.sv
// Shared types and constants for the CFU scratchpad responder.
package cfu_ram_pkg;

    localparam int         WORD_ADR_W  = 30;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } respState_t;

endpackage

// File: rtl/cfu_ram_responder_if.sv
// Wishbone classic bus between the CFU convolution engines and the scratchpad.
interface cfu_ram_responder_if;
    import cfu_ram_pkg::*;

    logic [WORD_ADR_W-1:0] cfu_ram_adr;
    logic [31:0]           cfu_ram_dat_mosi;
    logic [3:0]            cfu_ram_sel;
    logic                  cfu_ram_cyc;
    logic                  cfu_ram_stb;
    logic                  cfu_ram_we;
    logic [2:0]            cfu_ram_cti;
    logic [1:0]            cfu_ram_bte;
    logic [31:0]           cfu_ram_dat_miso;
    logic                  cfu_ram_ack;
    logic                  cfu_ram_err;

    modport master (
        output cfu_ram_adr, cfu_ram_dat_mosi, cfu_ram_sel, cfu_ram_cyc,
               cfu_ram_stb, cfu_ram_we, cfu_ram_cti, cfu_ram_bte,
        input  cfu_ram_dat_miso, cfu_ram_ack, cfu_ram_err
    );

    modport slave (
        input  cfu_ram_adr, cfu_ram_dat_mosi, cfu_ram_sel, cfu_ram_cyc,
               cfu_ram_stb, cfu_ram_we, cfu_ram_cti, cfu_ram_bte,
        output cfu_ram_dat_miso, cfu_ram_ack, cfu_ram_err
    );

endinterface

// File: rtl/cfu_ram_bank.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port. Contents are never cleared.
module cfu_ram_bank #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [3:0]       we_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [31:0]      wdat_i,
    output logic [31:0]      rdat_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // One access per cycle: enabled byte lanes are written and the old word is read out
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdat_i[8*b +: 8];
                end
            end
            rdat_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/cfu_ram_responder.sv
// Wishbone classic slave serving the CFU filter/image scratchpad, with a
// host preload port sharing the single RAM port and optional wait states.
module cfu_ram_responder
    import cfu_ram_pkg::*;
#(
    parameter  int                    DEPTH_WORDS = 1024,
    parameter  logic [WORD_ADR_W-1:0] BASE_ADR    = '0,
    parameter  int                    WAIT_STATES = 0,
    localparam int                    IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                      clk,
    input  logic                      reset,
    cfu_ram_responder_if.slave        bus,
    input  logic                      preload_valid,
    output logic                      preload_ready,
    input  logic [IDX_W-1:0]          preload_idx,
    input  logic [31:0]               preload_dat,
    output logic                      busy
);

    localparam logic [WORD_ADR_W-1:0] DEPTH_ADR = WORD_ADR_W'(DEPTH_WORDS);
    localparam logic [3:0]            WAIT_LAST = 4'(WAIT_STATES - 1);

    respState_t            state_q, state_d;
    logic [3:0]            waitCnt_q, waitCnt_d;
    logic                  inRange_q, inRange_d;
    logic                  isWrite_q, isWrite_d;

    logic                  busReq;
    logic                  capture;
    logic [WORD_ADR_W-1:0] reqOffset;
    logic                  reqInRange;
    logic                  respAck;
    logic                  respErr;

    logic                  ramEn;
    logic [3:0]            ramWe;
    logic [IDX_W-1:0]      ramAddr;
    logic [31:0]           ramWdat;
    logic [31:0]           ramRdat;

    logic                  unusedBits;

    assign busReq     = bus.cfu_ram_cyc & bus.cfu_ram_stb;
    assign capture    = (state_q == IDLE) & busReq & ~reset;
    assign reqOffset  = bus.cfu_ram_adr - BASE_ADR;
    assign reqInRange = reqOffset < DEPTH_ADR;
    assign unusedBits = ^{bus.cfu_ram_cti ^ CTI_CLASSIC, bus.cfu_ram_bte ^ BTE_LINEAR};

    // Response FSM next state: capture in IDLE, count wait states, one-cycle RESP
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        inRange_d = inRange_q;
        isWrite_d = isWrite_q;
        unique case (state_q)
            IDLE: begin
                if (busReq) begin
                    inRange_d = reqInRange;
                    isWrite_d = bus.cfu_ram_we;
                    waitCnt_d = '0;
                    state_d   = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!bus.cfu_ram_cyc) begin
                    state_d   = IDLE;
                    waitCnt_d = '0;
                end else if (waitCnt_q == WAIT_LAST) begin
                    state_d = RESP;
                end else begin
                    waitCnt_d = waitCnt_q + 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; RAM contents are left untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            inRange_q <= 1'b0;
            isWrite_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            inRange_q <= inRange_d;
            isWrite_q <= isWrite_d;
        end
    end

    // Single RAM port arbitration: a captured bus request beats a pending preload
    always_comb begin
        ramEn   = 1'b0;
        ramWe   = 4'b0000;
        ramAddr = '0;
        ramWdat = '0;
        if (capture) begin
            ramEn   = reqInRange;
            ramWe   = bus.cfu_ram_we ? bus.cfu_ram_sel : 4'b0000;
            ramAddr = reqOffset[IDX_W-1:0];
            ramWdat = bus.cfu_ram_dat_mosi;
        end else if (preload_valid && preload_ready) begin
            ramEn   = 1'b1;
            ramWe   = 4'b1111;
            ramAddr = preload_idx;
            ramWdat = preload_dat;
        end
    end

    cfu_ram_bank #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .clk    (clk),
        .en_i   (ramEn),
        .we_i   (ramWe),
        .addr_i (ramAddr),
        .wdat_i (ramWdat),
        .rdat_o (ramRdat)
    );

    assign respAck = (state_q == RESP) & inRange_q & ~reset;
    assign respErr = (state_q == RESP) & ~inRange_q & ~reset;

    assign bus.cfu_ram_ack      = respAck;
    assign bus.cfu_ram_err      = respErr;
    assign bus.cfu_ram_dat_miso = (respAck & ~isWrite_q) ? ramRdat : 32'h0;
    assign preload_ready        = (state_q == IDLE) & ~busReq & ~reset;
    assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_cfu_ram_responder.sv
// Self-checking bench for cfu_ram_responder: two instances (0 and 3 wait
// states) driven from one master model and compared to a word-array model.
`timescale 1ns/1ps
module tb_cfu_ram_responder;
    import cfu_ram_pkg::*;

    localparam int          DEPTH = 64;
    localparam int          IDXW  = 6;
    localparam logic [29:0] BASE  = 30'h0000_0200;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int          which;
    logic [29:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        cyc, stb, we;
    logic        plValid;
    logic [IDXW-1:0] plIdx;
    logic [31:0] plDat;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [2][DEPTH];

    cfu_ram_responder_if bus0();
    cfu_ram_responder_if bus3();

    logic rdy0, rdy3, busy0, busy3;
    logic ackObs, errObs, rdyObs, busyObs;
    logic [31:0] misoObs;

    assign bus0.cfu_ram_adr      = adr;
    assign bus0.cfu_ram_dat_mosi = wdat;
    assign bus0.cfu_ram_sel      = sel;
    assign bus0.cfu_ram_we       = we;
    assign bus0.cfu_ram_cyc      = (which == 0) & cyc;
    assign bus0.cfu_ram_stb      = (which == 0) & stb;
    assign bus0.cfu_ram_cti      = CTI_CLASSIC;
    assign bus0.cfu_ram_bte      = BTE_LINEAR;
    assign bus3.cfu_ram_adr      = adr;
    assign bus3.cfu_ram_dat_mosi = wdat;
    assign bus3.cfu_ram_sel      = sel;
    assign bus3.cfu_ram_we       = we;
    assign bus3.cfu_ram_cyc      = (which == 1) & cyc;
    assign bus3.cfu_ram_stb      = (which == 1) & stb;
    assign bus3.cfu_ram_cti      = CTI_CLASSIC;
    assign bus3.cfu_ram_bte      = BTE_LINEAR;

    assign ackObs  = (which == 0) ? bus0.cfu_ram_ack      : bus3.cfu_ram_ack;
    assign errObs  = (which == 0) ? bus0.cfu_ram_err      : bus3.cfu_ram_err;
    assign misoObs = (which == 0) ? bus0.cfu_ram_dat_miso : bus3.cfu_ram_dat_miso;
    assign rdyObs  = (which == 0) ? rdy0  : rdy3;
    assign busyObs = (which == 0) ? busy0 : busy3;

    cfu_ram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADR(BASE), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .preload_valid((which == 0) & plValid), .preload_ready(rdy0),
        .preload_idx(plIdx), .preload_dat(plDat), .busy(busy0)
    );

    cfu_ram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADR(BASE), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3),
        .preload_valid((which == 1) & plValid), .preload_ready(rdy3),
        .preload_idx(plIdx), .preload_dat(plDat), .busy(busy3)
    );

    // Reference rules: the window is [BASE, BASE+DEPTH) in plain integer arithmetic
    function automatic bit inRangeRef(input logic [29:0] a);
        longint la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + DEPTH);
    endfunction

    function automatic int idxRef(input logic [29:0] a);
        return int'(longint'(a) - longint'(BASE));
    endfunction

    function automatic int latRef();
        return (which == 0) ? 1 : 4;
    endfunction

    task automatic modelWrite(input int i, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) model[which][i][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Drives one classic transfer from a falling edge and reports what came back
    task automatic runXfer(input logic w, input logic [29:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int lat, output logic gotAck,
                           output logic gotErr, output logic [31:0] rd,
                           output logic twoCycle, output logic leak);
        lat = -1; gotAck = 1'b0; gotErr = 1'b0; rd = '0; twoCycle = 1'b0; leak = 1'b0;
        adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            if (ackObs || errObs) begin
                lat = c; gotAck = ackObs; gotErr = errObs; rd = misoObs;
            end else if (misoObs !== 32'h0) begin
                leak = 1'b1;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        if (ackObs || errObs) twoCycle = 1'b1;
        if (misoObs !== 32'h0) leak = 1'b1;
        total++;
        if (lat < 0) begin
            bad++;
            $display("[TB] FAIL xfer_timeout adr=%h: no ack/err seen, required one within 20 cycles", a);
        end
    endtask

    // Offers one preload word and waits for it to be accepted
    task automatic preloadWord(input int i, input logic [31:0] d);
        bit done = 0;
        plIdx = IDXW'(i); plDat = d; plValid = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (rdyObs === 1'b1) done = 1;
            @(negedge clk);
        end
        plValid = 1'b0;
        if (done) model[which][i] = d;
        total++;
        if (!done) begin
            bad++;
            $display("[TB] FAIL preload_timeout idx=%0d: ready never seen, required within 20 cycles", i);
        end
    endtask

    task automatic test_reset();
        int lat; logic a, e, tc, lk; logic [31:0] rd;
        bit quiet = 1;
        which = 0; reset = 1'b1; plValid = 1'b0;
        adr = BASE + 30'd1; wdat = 32'hCAFE_0001; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            if (ackObs !== 1'b0 || errObs !== 1'b0 || misoObs !== 32'h0 || rdyObs !== 1'b0) quiet = 0;
            @(negedge clk);
        end
        total++;
        if (!quiet) begin
            bad++; $display("[TB] FAIL reset_quiet: ack/err/miso/ready active during reset, required all 0");
        end
        reset = 1'b0;
        total++;
        if (busyObs !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_busy: got %b required 0", busyObs);
        end
        runXfer(1'b1, BASE + 30'd1, 32'hCAFE_0001, 4'hF, lat, a, e, rd, tc, lk);
        modelWrite(1, 32'hCAFE_0001, 4'hF);
        total++;
        if (lat != 1 || a !== 1'b1 || e !== 1'b0 || rd !== 32'h0 || tc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_first_xfer: lat=%0d ack=%b err=%b miso=%h long=%b required lat=1 ack=1 err=0 miso=0 long=0",
                     lat, a, e, rd, tc);
        end
    endtask

    task automatic test_preload_fill();
        for (int w = 0; w < 2; w++) begin
            which = w;
            for (int i = 0; i < DEPTH; i++) preloadWord(i, $urandom);
        end
    endtask

    task automatic test_preload_read();
        int lat; logic a, e, tc, lk; logic [31:0] rd;
        which = 0;
        preloadWord(5, 32'hDEAD_BEEF);
        runXfer(1'b0, BASE + 30'd5, 32'h0, 4'hF, lat, a, e, rd, tc, lk);
        total++;
        if (rd !== 32'hDEAD_BEEF) begin
            bad++; $display("[TB] FAIL preload_read_data: got %h required deadbeef", rd);
        end
        total++;
        if (a !== 1'b1 || e !== 1'b0 || tc !== 1'b0 || lat != 1) begin
            bad++; $display("[TB] FAIL preload_read_resp: ack=%b err=%b long=%b lat=%0d required 1 0 0 1", a, e, tc, lat);
        end
    endtask

    task automatic test_wait_states();
        int lat; logic a, e, tc, lk; logic [31:0] rd;
        bit noResp = 1;
        which = 1;
        preloadWord(5, 32'hDEAD_BEEF);
        runXfer(1'b0, BASE + 30'd5, 32'h0, 4'hF, lat, a, e, rd, tc, lk);
        total++;
        if (lat != 4 || a !== 1'b1 || rd !== 32'hDEAD_BEEF || tc !== 1'b0 || lk !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wait_read: lat=%0d ack=%b miso=%h long=%b leak=%b required lat=4 ack=1 miso=deadbeef long=0 leak=0",
                     lat, a, rd, tc, lk);
        end
        adr = BASE + 30'd5; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        total++;
        if (busyObs !== 1'b1) begin
            bad++; $display("[TB] FAIL wait_busy: got %b required 1", busyObs);
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ackObs !== 1'b0 || errObs !== 1'b0) noResp = 0;
        end
        total++;
        if (!noResp || busyObs !== 1'b0) begin
            bad++; $display("[TB] FAIL wait_abort: response=%b busy=%b required no response and busy=0", !noResp, busyObs);
        end
        runXfer(1'b0, BASE + 30'd6, 32'h0, 4'hF, lat, a, e, rd, tc, lk);
        total++;
        if (lat != 4 || a !== 1'b1 || rd !== model[1][6]) begin
            bad++; $display("[TB] FAIL wait_after_abort: lat=%0d ack=%b miso=%h required lat=4 ack=1 miso=%h", lat, a, rd, model[1][6]);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic a, e, tc, lk; logic [31:0] rd;
        which = 0;
        runXfer(1'b0, BASE + 30'(DEPTH), 32'h0, 4'hF, lat, a, e, rd, tc, lk);
        total++;
        if (e !== 1'b1 || a !== 1'b0 || rd !== 32'h0 || tc !== 1'b0 || lat != 1) begin
            bad++; $display("[TB] FAIL oor_read: err=%b ack=%b miso=%h long=%b lat=%0d required 1 0 0 0 1", e, a, rd, tc, lat);
        end
        runXfer(1'b1, BASE - 30'd1, 32'h5A5A_A5A5, 4'hF, lat, a, e, rd, tc, lk);
        total++;
        if (e !== 1'b1 || a !== 1'b0 || rd !== 32'h0 || tc !== 1'b0) begin
            bad++; $display("[TB] FAIL oor_write: err=%b ack=%b miso=%h long=%b required 1 0 0 0", e, a, rd, tc);
        end
        runXfer(1'b0, BASE + 30'(DEPTH - 1), 32'h0, 4'hF, lat, a, e, rd, tc, lk);
        total++;
        if (a !== 1'b1 || rd !== model[0][DEPTH-1]) begin
            bad++; $display("[TB] FAIL oor_ram_top: ack=%b miso=%h required ack=1 miso=%h", a, rd, model[0][DEPTH-1]);
        end
        runXfer(1'b0, BASE, 32'h0, 4'hF, lat, a, e, rd, tc, lk);
        total++;
        if (a !== 1'b1 || rd !== model[0][0]) begin
            bad++; $display("[TB] FAIL oor_ram_bottom: ack=%b miso=%h required ack=1 miso=%h", a, rd, model[0][0]);
        end
    endtask

    task automatic test_byte_write();
        int lat; logic a, e, tc, lk; logic [31:0] rd;
        which = 0;
        runXfer(1'b1, BASE + 30'd7, 32'h1122_3344, 4'hF, lat, a, e, rd, tc, lk);
        modelWrite(7, 32'h1122_3344, 4'hF);
        runXfer(1'b1, BASE + 30'd7, 32'hAABB_CCDD, 4'b0101, lat, a, e, rd, tc, lk);
        modelWrite(7, 32'hAABB_CCDD, 4'b0101);
        runXfer(1'b0, BASE + 30'd7, 32'h0, 4'hF, lat, a, e, rd, tc, lk);
        total++;
        if (rd !== 32'h11BB_33DD || rd !== model[0][7]) begin
            bad++; $display("[TB] FAIL byte_write: got %h required 11bb33dd", rd);
        end
        runXfer(1'b1, BASE + 30'd7, 32'hFFFF_FFFF, 4'b0000, lat, a, e, rd, tc, lk);
        total++;
        if (a !== 1'b1 || e !== 1'b0) begin
            bad++; $display("[TB] FAIL sel0_ack: ack=%b err=%b required 1 0", a, e);
        end
        runXfer(1'b0, BASE + 30'd7, 32'h0, 4'hF, lat, a, e, rd, tc, lk);
        total++;
        if (rd !== 32'h11BB_33DD) begin
            bad++; $display("[TB] FAIL sel0_unchanged: got %h required 11bb33dd", rd);
        end
    endtask

    task automatic test_random();
        int lat; logic a, e, tc, lk; logic [31:0] rd;
        logic [29:0] ra; logic [31:0] rdat; logic [3:0] rsel; logic rwe;
        bit expIn; logic [31:0] expRd;
        for (int n = 0; n < 40; n++) begin
            which = int'($urandom_range(0, 1));
            ra    = BASE + 30'($urandom_range(0, DEPTH + 3)) - 30'd2;
            rdat  = $urandom;
            rsel  = 4'($urandom_range(0, 15));
            rwe   = 1'($urandom_range(0, 1));
            expIn = inRangeRef(ra);
            expRd = (expIn && !rwe) ? model[which][idxRef(ra)] : 32'h0;
            runXfer(rwe, ra, rdat, rsel, lat, a, e, rd, tc, lk);
            if (expIn && rwe) modelWrite(idxRef(ra), rdat, rsel);
            total++;
            if (lat != latRef() || a !== expIn || e !== !expIn || rd !== expRd || tc !== 1'b0 || lk !== 1'b0) begin
                bad++;
                $display("[TB] FAIL random_%0d dut=%0d adr=%h we=%b: lat=%0d ack=%b err=%b miso=%h long=%b leak=%b required lat=%0d ack=%b err=%b miso=%h long=0 leak=0",
                         n, which, ra, rwe, lat, a, e, rd, tc, lk, latRef(), expIn, !expIn, expRd);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic a, e, tc, lk; logic [31:0] rd;
        logic [31:0] newDat;
        logic [31:0] got [3];
        logic [31:0] want [3];
        int acks = 0; int lastAckCycle = -1;
        bit rdyDuring = 0; bit dbl = 0; logic prevAck = 1'b0;
        which = 0;
        for (int k = 0; k < 3; k++) want[k] = model[0][9+k];
        newDat = $urandom;
        plIdx = IDXW'(9); plDat = newDat; plValid = 1'b1;
        adr = BASE + 30'd9; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        for (int c = 1; c <= 30 && acks < 3; c++) begin
            @(negedge clk);
            if (rdyObs !== 1'b0) rdyDuring = 1;
            if (ackObs === 1'b1) begin
                if (prevAck) dbl = 1;
                got[acks] = misoObs;
                acks++;
                lastAckCycle = c;
                if (acks < 3) adr = BASE + 30'(9 + acks);
                else begin cyc = 1'b0; stb = 1'b0; end
            end
            prevAck = ackObs;
        end
        @(negedge clk);
        if (ackObs !== 1'b0) dbl = 1;
        total++;
        if (rdyObs !== 1'b1) begin
            bad++; $display("[TB] FAIL b2b_ready_idle: got %b required 1 once stb drops", rdyObs);
        end
        @(negedge clk);
        plValid = 1'b0;
        model[0][9] = newDat;
        total++;
        if (acks != 3 || lastAckCycle != 5 || dbl || rdyDuring) begin
            bad++;
            $display("[TB] FAIL b2b_stream: acks=%0d last=%0d double=%b ready_during=%b required 3 5 0 0",
                     acks, lastAckCycle, dbl, rdyDuring);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (k < acks && got[k] !== want[k]) begin
                bad++; $display("[TB] FAIL b2b_data_%0d: got %h required %h", k, got[k], want[k]);
            end
        end
        runXfer(1'b0, BASE + 30'd9, 32'h0, 4'hF, lat, a, e, rd, tc, lk);
        total++;
        if (rd !== newDat) begin
            bad++; $display("[TB] FAIL b2b_preload_late: got %h required %h", rd, newDat);
        end
    endtask

    // Sequence all scenarios, then report
    initial begin
        reset = 1'b1; which = 0; plValid = 1'b0; plIdx = '0; plDat = '0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
        test_reset();
        test_preload_fill();
        test_preload_read();
        test_wait_states();
        test_out_of_range();
        test_byte_write();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound in case a scenario stalls
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at 1ms, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
